// File: rtl/hififo_pkg.sv
// Shared constants and types for the hififo PCIe request arbiters.
package hififo_pkg;

  localparam int HIFIFO_NCH_DEFAULT       = 4;
  localparam int HIFIFO_BURST_CNT_W       = 16;
  localparam int HIFIFO_STALL_MAX_DEFAULT = 255;
  localparam int HIFIFO_COUNT_W           = 5;

  // Channel-index width; a single channel still needs one bit of index.
  function automatic int hififo_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/hififo_rr_pick.sv
// Rotating-priority selector: returns the first set request bit found
// searching upward from last_i+1, wrapping modulo NCH. Purely combinational.
module hififo_rr_pick
  import hififo_pkg::*;
#(
  parameter int NCH = HIFIFO_NCH_DEFAULT,
  parameter int IW  = hififo_idx_w(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic [IW-1:0]  last_i,
  output logic           found_o,
  output logic [IW-1:0]  idx_o
);

  // cand[k] is the channel examined at search position k (k=0 is highest priority).
  logic [IW-1:0]  cand [NCH];
  logic [NCH-1:0] hit;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_cand
    localparam int K = gi + 1;
    assign cand[gi] = IW'((int'(last_i) + K) % NCH);
    assign hit[gi]  = req_i[cand[gi]];
  end

  // Lowest search position with a request wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (hit[k]) begin
        found_o = 1'b1;
        idx_o   = cand[k];
      end
    end
  end

endmodule

// File: rtl/hififo_tx_write_arbiter.sv
// Shares the PCIe TX write-request port among NCH to-PC FIFO engines.
// One burst at a time, rotating priority, grant locked until the last beat
// is accepted; keeps per-channel completed-burst counters and a sticky
// stall-error flag for a granted channel that stops offering beats.
module hififo_tx_write_arbiter
  import hififo_pkg::*;
#(
  parameter int NCH       = HIFIFO_NCH_DEFAULT,
  parameter int DW        = 64,
  parameter int AW        = 64,
  parameter int STALL_MAX = HIFIFO_STALL_MAX_DEFAULT
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NCH-1:0]                      enable,
  input  logic [NCH-1:0]                      in_valid,
  output logic [NCH-1:0]                      in_ready,
  input  logic [NCH*DW-1:0]                   in_data,
  input  logic [NCH*AW-1:0]                   in_addr,
  input  logic [NCH-1:0]                      in_last,
  input  logic [NCH*HIFIFO_COUNT_W-1:0]       in_count,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DW-1:0]                       out_data,
  output logic [AW-1:0]                       out_addr,
  output logic                                out_last,
  output logic [HIFIFO_COUNT_W-1:0]           out_count,
  output logic                                busy,
  output logic [hififo_idx_w(NCH)-1:0]        grant,
  output logic [NCH*HIFIFO_BURST_CNT_W-1:0]   burst_count,
  output logic                                stall_error
);

  localparam int IW  = hififo_idx_w(NCH);
  localparam int CW  = HIFIFO_BURST_CNT_W;
  localparam int NW  = HIFIFO_COUNT_W;
  localparam int SW  = $clog2(STALL_MAX + 1);
  localparam logic [SW-1:0] STALL_LIM = SW'(STALL_MAX);
  localparam logic [IW-1:0] LAST_RST  = IW'(NCH - 1);

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [IW-1:0]    last_q, last_d;
  logic [SW-1:0]    stall_cnt_q, stall_cnt_d;
  logic             stall_error_q, stall_error_d;
  logic [CW-1:0]    burst_count_q [NCH];

  logic [NCH-1:0]   eligible;
  logic             pick_found;
  logic [IW-1:0]    pick_idx;
  logic             xfer;
  logic             burst_end;

  assign eligible = in_valid & enable;

  hififo_rr_pick #(
    .NCH (NCH),
    .IW  (IW)
  ) u_pick (
    .req_i   (eligible),
    .last_i  (last_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Output mux driven from the registered grant; only live during a burst.
  always_comb begin
    out_data  = in_data[int'(grant_q)*DW +: DW];
    out_addr  = in_addr[int'(grant_q)*AW +: AW];
    out_count = in_count[int'(grant_q)*NW +: NW];
    out_last  = in_last[grant_q];
    out_valid = (state_q == ARB_BURST) && in_valid[grant_q];
    in_ready  = '0;
    if (state_q == ARB_BURST) begin
      in_ready[grant_q] = out_ready;
    end
  end

  assign xfer = out_valid && out_ready;

  // Next-state: arbitration in IDLE, grant lock and stall watch in BURST.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    stall_cnt_d   = stall_cnt_q;
    stall_error_d = stall_error_q;
    burst_end     = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        stall_cnt_d = '0;
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ARB_BURST;
        end
      end
      ARB_BURST: begin
        if (xfer) begin
          stall_cnt_d = '0;
          if (out_last) begin
            burst_end = 1'b1;
            last_d    = grant_q;
            state_d   = ARB_IDLE;
          end
        end else if (!in_valid[grant_q]) begin
          // Source went quiet mid-burst; backpressure alone is not a stall.
          if (stall_cnt_q != STALL_LIM) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
          if (stall_cnt_d == STALL_LIM) begin
            stall_error_d = 1'b1;
          end
        end else begin
          stall_cnt_d = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ARB_IDLE;
      grant_q       <= '0;
      last_q        <= LAST_RST;
      stall_cnt_q   <= '0;
      stall_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      stall_cnt_q   <= stall_cnt_d;
      stall_error_q <= stall_error_d;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_cnt
    // Completed-burst counter for channel gi, wraps naturally.
    always_ff @(posedge clock) begin
      if (reset) begin
        burst_count_q[gi] <= '0;
      end else if (burst_end && (grant_q == IW'(gi))) begin
        burst_count_q[gi] <= burst_count_q[gi] + 1'b1;
      end
    end
    assign burst_count[gi*CW +: CW] = burst_count_q[gi];
  end

  assign busy        = (state_q == ARB_BURST);
  assign grant       = grant_q;
  assign stall_error = stall_error_q;

endmodule

// File: tb/tb_hififo_tx_write_arbiter.sv
// Directed bench for hififo_tx_write_arbiter: per-channel burst sources,
// a transfer log, and hand-computed grant orders / timings.
module tb_hififo_tx_write_arbiter;

  localparam int NCH  = 4;
  localparam int DW   = 64;
  localparam int AW   = 64;
  localparam int SMAX = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic [NCH-1:0]    enable;
  logic [NCH-1:0]    in_valid;
  logic [NCH-1:0]    in_ready;
  logic [NCH*DW-1:0] in_data;
  logic [NCH*AW-1:0] in_addr;
  logic [NCH-1:0]    in_last;
  logic [NCH*5-1:0]  in_count;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [AW-1:0]     out_addr;
  logic              out_last;
  logic [4:0]        out_count;
  logic              busy;
  logic [1:0]        grant;
  logic [NCH*16-1:0] burst_count;
  logic              stall_error;

  always #5 clock = ~clock;

  hififo_tx_write_arbiter #(
    .NCH       (NCH),
    .DW        (DW),
    .AW        (AW),
    .STALL_MAX (SMAX)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_addr     (in_addr),
    .in_last     (in_last),
    .in_count    (in_count),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .out_last    (out_last),
    .out_count   (out_count),
    .busy        (busy),
    .grant       (grant),
    .burst_count (burst_count),
    .stall_error (stall_error)
  );

  int n_chk = 0;
  int n_err = 0;

  // Source model state.
  int             beat   [NCH];
  int             bno    [NCH];
  int             bursts [NCH];
  logic [NCH-1:0] pause;
  bit             toggle_ready;
  int             cyc;
  bit             nongrant_rdy;

  // Transfer log.
  int   q_ch[$];
  int   q_src[$];
  int   q_beat[$];
  int   q_cyc[$];
  logic q_last[$];
  int   exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("chk  %s: got=%0h ok", tag, got);
    end
  endtask

  task automatic drive();
    for (int c = 0; c < NCH; c++) begin
      in_valid[c]          = (bursts[c] != 0) && !pause[c];
      in_data[c*DW +: DW]  = {16'(c), 16'(bno[c]), 32'(beat[c])};
      in_addr[c*AW +: AW]  = {32'(c), 32'(bno[c] * 128)};
      in_last[c]           = (beat[c] == 15);
      in_count[c*5 +: 5]   = 5'd16;
    end
  endtask

  task automatic zero_model();
    for (int c = 0; c < NCH; c++) begin
      beat[c]   = 0;
      bno[c]    = 0;
      bursts[c] = 0;
    end
    pause = '0;
  endtask

  task automatic clear_q();
    q_ch.delete(); q_src.delete(); q_beat.delete(); q_cyc.delete(); q_last.delete();
    exp_q.delete();
  endtask

  // One clock: sample at negedge, then advance sources just after posedge.
  task automatic step();
    logic [NCH-1:0] fired;
    @(negedge clock);
    fired = in_valid & in_ready;
    if (out_valid && out_ready) begin
      q_ch.push_back(int'(grant));
      q_src.push_back(int'(out_data[63:48]));
      q_beat.push_back(int'(out_data[31:0]));
      q_cyc.push_back(cyc);
      q_last.push_back(out_last);
    end
    for (int c = 0; c < NCH; c++) begin
      if (in_ready[c] && (c != int'(grant))) nongrant_rdy = 1'b1;
    end
    @(posedge clock);
    #1;
    cyc++;
    for (int c = 0; c < NCH; c++) begin
      if (fired[c]) begin
        if (beat[c] == 15) begin
          beat[c] = 0;
          bno[c]++;
          if (bursts[c] > 0) bursts[c]--;
        end else begin
          beat[c]++;
        end
      end
    end
    if (toggle_ready) out_ready = ~out_ready;
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    zero_model();
    drive();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    clear_q();
  endtask

  // Compare the log against exp_q: 16 beats per expected burst, in order.
  task automatic verify(input string tag);
    int bad;
    chk($sformatf("%s nxfer", tag), 64'(q_ch.size()), 64'(exp_q.size() * 16));
    if (q_ch.size() == exp_q.size() * 16) begin
      for (int k = 0; k < exp_q.size(); k++) begin
        chk($sformatf("%s b%0d ch", tag, k), 64'(q_ch[16*k]), 64'(exp_q[k]));
        bad = 0;
        for (int j = 0; j < 16; j++) begin
          if (q_ch[16*k+j] != exp_q[k] || q_src[16*k+j] != exp_q[k] ||
              q_beat[16*k+j] != j || q_last[16*k+j] != (j == 15)) bad++;
        end
        chk($sformatf("%s b%0d beats_bad", tag, k), 64'(bad), 64'd0);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    enable       = '1;
    out_ready    = 1'b1;
    toggle_ready = 1'b0;
    cyc          = 0;
    nongrant_rdy = 1'b0;
    in_valid = '0; in_data = '0; in_addr = '0; in_last = '0; in_count = '0;
    do_reset();

    // Reset state.
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst grant", 64'(grant), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd0);
    chk("rst burst_count", burst_count, 64'd0);
    chk("rst stall_error", 64'(stall_error), 64'd0);

    // Single channel 2, one 16-beat burst.
    bursts[2] = 1;
    drive();
    #1;
    chk("t1 ov_at_valid", 64'(out_valid), 64'd0);
    step();
    chk("t1 grant", 64'(grant), 64'd2);
    chk("t1 busy", 64'(busy), 64'd1);
    chk("t1 ov_next", 64'(out_valid), 64'd1);
    chk("t1 count", 64'(out_count), 64'd16);
    repeat (20) step();
    exp_q = '{2};
    verify("t1");
    chk("t1 span", 64'(q_cyc[15] - q_cyc[0]), 64'd15);
    chk("t1 bc2", 64'(burst_count[2*16 +: 16]), 64'd1);
    chk("t1 busy_end", 64'(busy), 64'd0);

    // Channels 0,1,3 contending from reset.
    do_reset();
    bursts[0] = 2; bursts[1] = 2; bursts[3] = 2;
    drive();
    repeat (115) step();
    exp_q = '{0, 1, 3, 0, 1, 3};
    verify("t2");
    chk("t2 bc", burst_count, {16'd2, 16'd0, 16'd2, 16'd2});

    // Ch1 bursting; ch0 arrives mid-burst and ch1 loses enable mid-burst.
    clear_q();
    bursts[1] = 1;
    drive();
    repeat (6) step();
    enable[1] = 1'b0;
    bursts[0] = 1;
    drive();
    repeat (45) step();
    exp_q = '{1, 0};
    verify("t3");
    chk("t3 idle_gap", 64'(q_cyc[16] - q_cyc[15]), 64'd2);
    enable = '1;

    // Backpressure: out_ready toggles; ch2 valid but disabled.
    clear_q();
    enable[2]    = 1'b0;
    bursts[2]    = 1;
    bursts[3]    = 1;
    nongrant_rdy = 1'b0;
    toggle_ready = 1'b1;
    out_ready    = 1'b1;
    drive();
    repeat (45) step();
    toggle_ready = 1'b0;
    out_ready    = 1'b1;
    exp_q = '{3};
    verify("t4");
    chk("t4 span", 64'(q_cyc[15] - q_cyc[0]), 64'd30);
    chk("t4 nongrant_rdy", 64'(nongrant_rdy), 64'd0);
    chk("t4 stall_error", 64'(stall_error), 64'd0);
    bursts[2] = 0;
    enable    = '1;
    drive();
    step();

    // Stall: ch0 drops valid for 8 cycles after beat 5.
    clear_q();
    bursts[0] = 1;
    drive();
    guard = 0;
    while (q_ch.size() < 5 && guard < 30) begin
      step();
      guard++;
    end
    chk("t5 five_beats", 64'(q_ch.size()), 64'd5);
    pause[0] = 1'b1;
    drive();
    repeat (7) step();
    chk("t5 err_after7", 64'(stall_error), 64'd0);
    step();
    chk("t5 err_after8", 64'(stall_error), 64'd1);
    pause[0] = 1'b0;
    drive();
    repeat (20) step();
    exp_q = '{0};
    verify("t5");
    chk("t5 gap", 64'(q_cyc[5] - q_cyc[4]), 64'd9);
    chk("t5 err_sticky", 64'(stall_error), 64'd1);
    chk("t5 bc0", 64'(burst_count[15:0]), 64'd4);

    // Reset on beat 7 of a ch1 burst.
    clear_q();
    bursts[1] = 1;
    drive();
    guard = 0;
    while (q_ch.size() < 6 && guard < 30) begin
      step();
      guard++;
    end
    chk("t6 six_beats", 64'(q_ch.size()), 64'd6);
    reset = 1'b1;
    step();
    reset = 1'b0;
    zero_model();
    drive();
    #1;
    chk("t6 out_valid", 64'(out_valid), 64'd0);
    chk("t6 busy", 64'(busy), 64'd0);
    chk("t6 grant", 64'(grant), 64'd0);
    chk("t6 burst_count", burst_count, 64'd0);
    chk("t6 stall_error", 64'(stall_error), 64'd0);
    chk("t6 in_ready", 64'(in_ready), 64'd0);
    clear_q();
    bursts[0] = 1;
    bursts[1] = 1;
    drive();
    repeat (40) step();
    exp_q = '{0, 1};
    verify("t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hififo_tx_write_arbiter.md
Name: hififo_tx_write_arbiter

Overview:
Shares the single PCIe TX write-request port among NCH to-PC FIFO engines, such as the TPC FIFO channels. Each engine offers 16-word write bursts with address, count and last marker. The arbiter grants one engine at a time with rotating priority and locks the grant until that burst's last beat is accepted. It also keeps per-channel completed-burst counters and a sticky stall-error flag for the status registers.

Parameters:
NCH, 4, number of requesting channels (2..8)
DW, 64, data width per beat
AW, 64, write address width
STALL_MAX, 255, max consecutive cycles a granted channel may drop valid mid-burst before the error flag sets

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high
enable  input  NCH  per-channel arbitration enable; gates new grants only
in_valid  input  NCH  per-channel beat valid
in_ready  output  NCH  per-channel beat accepted
in_data  input  NCH*DW  flattened beat data, channel i at [i*DW +: DW]
in_addr  input  NCH*AW  flattened burst address
in_last  input  NCH  last beat of burst
in_count  input  NCH*5  burst length in beats
out_valid  output  1  to PCI TX
out_ready  input  1  from PCI TX
out_data  output  DW  muxed data
out_addr  output  AW  muxed address
out_last  output  1  muxed last
out_count  output  5  muxed count
busy  output  1  burst in progress
grant  output  clog2(NCH)  current or most recent channel index
burst_count  output  NCH*16  completed bursts per channel, wrapping
stall_error  output  1  sticky; cleared only by reset

Behaviour:
- Reset values:
  - busy=0, grant=0, last-served pointer=NCH-1, out_valid=0, in_ready=0
  - burst_count all 0, stall_error=0, stall counter 0
- States: IDLE, BURST.
- IDLE:
  - eligible = in_valid & enable.
  - If eligible≠0, pick the first eligible index searching upward from last-served+1, with wrap modulo NCH.
  - Register grant, set busy and move to BURST on the next edge.
  - Arbitration latency is 1 cycle from valid to out_valid.
- BURST:
  - out_* = in_*[grant], combinational mux from the registered grant.
  - out_valid = in_valid[grant].
  - in_ready[grant] = out_ready; all other in_ready = 0.
  - Beat transfers when out_valid&&out_ready.
- Burst end: a transfer with out_last=1 returns the state to IDLE on the next edge.
  - Last-served pointer is set to grant.
  - burst_count[grant] increments, wrapping 0xFFFF→0.
  - At least one idle cycle always separates bursts; no same-cycle re-grant.
- Grant lock: the grant never changes in BURST, regardless of enable, in_valid or other requesters.
  - Deasserting enable[grant] mid-burst has no effect until the burst ends.
- Stall watch: in BURST with in_valid[grant]=0, the stall counter increments (saturating).
  - Any transfer, or the return to IDLE, clears the counter.
  - When the counter reaches STALL_MAX, stall_error sets.
  - The burst is not aborted.
- out_ready low with valid high (backpressure) does not count as a stall.
- Single eligible channel: it is served on every burst; fairness only applies among contenders.
- Eligible set empty: stay in IDLE; out_valid=0.
- Reset mid-burst: next edge returns to IDLE with all outputs at reset values.
  - The partial burst is dropped; the TX side must also be reset.
- in_count is passed through; the arbiter checks burst length only via in_last.

Decomposition:
- Package hififo_pkg: constants for channel-index width, burst counter width (16), and default STALL_MAX.
- Sub-module hififo_rr_pick: combinational rotating-priority selector.
  - Inputs: request vector, last-served index.
  - Outputs: found flag, chosen index.
  - Reusable for the read-request arbiter.

Test Plan:
- Single channel 2 requests a 16-beat burst, out_ready=1 → grant=2 one cycle after valid; 16 transfers with out_last on beat 16; burst_count[2]=1; busy drops the next cycle.
- Channels 0,1,3 request continuously, starting from reset → grant order 0,1,3,0,1,3; no channel served twice while another waits.
- Channel 1 bursting; channel 0 raises valid mid-burst → channel 1 finishes all 16 beats first; channel 0 is granted after exactly one idle cycle.
- out_ready toggles 1,0,1,0 for the whole burst → 16 beats delivered in order; in_ready of non-granted channels stays 0; stall_error stays 0.
- STALL_MAX=8; the granted channel drops valid for 8 cycles after beat 5 → stall_error=1 and stays set; the burst resumes and completes normally.
- Reset asserted on beat 7 of a burst → next cycle out_valid=0, busy=0, grant=0, burst_count=0; fresh arbitration begins at channel 0.
